// File: rtl/icache_assoc.sv
// icache_assoc: 1- or 2-way set-associative instruction cache with a single-line refill engine.
// Latency: hit data returned combinationally in the request cycle; a miss costs REQ + WORDS_PER_LINE beats.
// Backpressure: pc_stall holds the core on a miss and while refilling; mem_req is held until mem_gnt.
// Optional feature macro: ICACHE_PERF_CNT_EN adds hit_cnt / miss_cnt outputs.
`timescale 1ns/1ps
module icache_assoc #(
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int NUM_WAYS       = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic        flush,
  output logic [31:0] rd,
  output logic        rd_valid,
  output logic        pc_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int O  = $clog2(WORDS_PER_LINE);
  localparam int I  = $clog2(NUM_SETS);
  localparam int TW = 32 - O - I - 2;   // tag width
  localparam int LW = 32 - O - 2;       // line address width (index + tag)
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;

  // Storage arrays: tag and data are never reset, only valid/LRU are.
  logic [31:0]         data_q [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
  logic [TW-1:0]       tag_q  [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
  logic [NUM_SETS-1:0] lru_q;            // per set: way NOT most recently used

  state_e         state_q;
  logic           mem_req_q;
  logic [LW-1:0]  miss_line_q;
  logic [O-1:0]   beat_q;
  logic           flush_pend_q;
  logic           victim_q;

  logic [O-1:0]   off;
  logic [I-1:0]   idx;
  logic [TW-1:0]  tag;
  logic [1:0]     match;
  logic           hit_way;
  logic           lookup_hit;
  logic           idle;
  logic           rd_hit;
  logic           miss_start;
  logic           victim;
  logic [I-1:0]   fill_idx;
  logic [TW-1:0]  fill_tag;
  logic           fill_beat;
  logic           fill_last;
  logic           unused_pc_bits;

  assign off      = pc[O+1:2];
  assign idx      = pc[O+I+1:O+2];
  assign tag      = pc[31:O+I+2];
  assign fill_idx = miss_line_q[I-1:0];
  assign fill_tag = miss_line_q[LW-1:I];
  assign unused_pc_bits = ^pc[1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    match = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
    end
  end

  // With one way match[1] stays 0, so the hit way collapses to way 0.
  assign hit_way    = match[1];
  assign lookup_hit = pc_valid && (|match);
  assign idle       = (state_q == IDLE);
  assign rd_hit     = lookup_hit && idle;
  assign miss_start = idle && pc_valid && !lookup_hit;
  assign fill_beat  = (state_q == FILL) && mem_rvalid;
  assign fill_last  = fill_beat && (&beat_q);

  assign rd       = rd_hit ? data_q[hit_way][idx][off] : NOP;
  assign rd_valid = rd_hit;
  assign pc_stall = (pc_valid && !lookup_hit) || !idle;
  assign mem_req  = mem_req_q;
  assign mem_addr = {miss_line_q, {(O+2){1'b0}}};

  // Victim choice: first invalid way (way 0 first), else the set's LRU way.
  always_comb begin
    victim = 1'b0;
    if (NUM_WAYS == 2) begin
      if (!valid_q[0][idx])                victim = 1'b0;
      else if (!valid_q[NUM_WAYS-1][idx])  victim = 1'b1;
      else                                 victim = lru_q[idx];
    end
  end

  // Refill writes: one word per beat into the latched victim way, tag on the final beat.
  always_ff @(posedge CLK) begin
    if (fill_beat) begin
      data_q[victim_q][fill_idx][beat_q] <= mem_rdata;
      if (&beat_q) begin
        tag_q[victim_q][fill_idx] <= fill_tag;
      end
    end
  end

  // Valid and LRU maintenance: flushes, line installs and hit recency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
      lru_q <= '0;
    end else if (idle && flush) begin
      for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
      lru_q <= '0;
    end else if (fill_last) begin
      if (flush_pend_q || flush) begin
        // A flush seen during the refill wipes everything, including the new line.
        for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
        lru_q <= '0;
      end else begin
        valid_q[victim_q][fill_idx] <= 1'b1;
        if (NUM_WAYS == 2) lru_q[fill_idx] <= ~victim_q;
      end
    end else if (rd_hit && (NUM_WAYS == 2)) begin
      lru_q[idx] <= ~hit_way;
    end
  end

  // Miss handling FSM: IDLE -> REQ (hold mem_req) -> FILL (count beats) -> IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      miss_line_q  <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      victim_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          flush_pend_q <= 1'b0;
          if (miss_start) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            miss_line_q <= pc[31:O+2];
            victim_q    <= victim;
            beat_q      <= '0;
          end
        end
        REQ: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_gnt) begin
            state_q   <= FILL;
            mem_req_q <= 1'b0;
          end
        end
        FILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_rvalid) begin
            beat_q <= beat_q + O'(1);
            if (&beat_q) begin
              state_q      <= IDLE;
              flush_pend_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit)     hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Testbench for icache_assoc: directed scenarios followed by random fetch traffic
// checked against a per-set recency-list model of a 2-way, 16-set, 8-word cache.
`timescale 1ns/1ps
module tb_icache_assoc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rd;
  logic        rd_valid;
  logic        pc_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  int          exp_hits = 0;
  int          exp_miss = 0;
`endif

  int checks = 0;
  int errors = 0;

  // Model: per set, up to two resident line numbers ordered most- then least-recently used.
  logic [26:0] mru_l [16];
  logic [26:0] lru_l [16];
  int          n_res [16];

  logic        last_hit;
  logic [31:0] last_rd;

  icache_assoc #(.NUM_SETS(16), .WORDS_PER_LINE(8), .NUM_WAYS(2)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .rd         (rd),
    .rd_valid   (rd_valid),
    .pc_stall   (pc_stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Backing memory contents; line 0x100 holds 0xA0..0xA7.
  function automatic logic [31:0] word_val(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:5] == 27'h8) return 32'hA0 + {29'b0, w[4:2]};
    return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    int s;
    s = int'(a[8:5]);
    return (n_res[s] > 0 && mru_l[s] == a[31:5]) || (n_res[s] > 1 && lru_l[s] == a[31:5]);
  endfunction

  // Use of a line (hit or fill) makes it most recent; a third line evicts the least recent.
  task automatic model_touch(input logic [31:0] a);
    int s;
    s = int'(a[8:5]);
    if (n_res[s] > 0 && mru_l[s] == a[31:5]) begin
      // already most recent
    end else if (n_res[s] > 1 && lru_l[s] == a[31:5]) begin
      lru_l[s] = mru_l[s];
      mru_l[s] = a[31:5];
    end else begin
      if (n_res[s] > 0) lru_l[s] = mru_l[s];
      mru_l[s] = a[31:5];
      if (n_res[s] < 2) n_res[s]++;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) n_res[s] = 0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    pc = 32'h100;
    pc_valid = 1'b1;
    #1;
    chk("rst_rd", rd, NOP);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_stall_pcv1", pc_stall, 1'b1);
    pc_valid = 1'b0;
    #1;
    chk1("rst_stall_pcv0", pc_stall, 1'b0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_clear();
`ifdef ICACHE_PERF_CNT_EN
    exp_hits = 0;
    exp_miss = 0;
`endif
  endtask

  task automatic idle_step(input logic fl);
    pc_valid = 1'b0;
    flush = fl;
    mem_gnt = ($urandom_range(0, 1) == 1);
    mem_rvalid = ($urandom_range(0, 1) == 1);
    mem_rdata = $urandom;
    @(negedge CLK);
    chk1("idle_rd_valid", rd_valid, 1'b0);
    chk("idle_rd", rd, NOP);
    chk1("idle_stall", pc_stall, 1'b0);
    chk1("idle_mem_req", mem_req, 1'b0);
    @(posedge CLK); #1;
    flush = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (fl) model_clear();
  endtask

  // Services one refill; flush_beat/abort_beat < 0 disable those injections.
  task automatic refill(input logic [31:0] a, input int flush_beat, input int abort_beat);
    logic [31:0] line;
    int n;
    line = {a[31:5], 5'b0};
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk1("req_mem_req", mem_req, 1'b1);
    chk("req_mem_addr", mem_addr, line);
    chk1("req_stall", pc_stall, 1'b1);
    chk1("req_rd_valid", rd_valid, 1'b0);
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'b1;            // stray beats before the grant must be ignored
      mem_rdata = $urandom;
      @(posedge CLK); #1;
    end
    mem_rvalid = 1'b0;
    chk("req_addr_stable", mem_addr, line);
    mem_gnt = 1'b1;
    @(posedge CLK); #1;
    mem_gnt = 1'b0;
    chk1("gnt_req_drop", mem_req, 1'b0);
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge CLK); #1;
        chk1("fill_stall", pc_stall, 1'b1);
      end
      if (b == abort_beat) begin
        RST_N = 1'b0;
        #1;
        chk1("abort_mem_req", mem_req, 1'b0);
        chk1("abort_stall", pc_stall, pc_valid);
        chk("abort_rd", rd, NOP);
        pc_valid = 1'b0;
        model_clear();
`ifdef ICACHE_PERF_CNT_EN
        exp_hits = 0;
        exp_miss = 0;
`endif
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
          mem_rvalid = 1'b1;
          mem_rdata = $urandom;
          @(posedge CLK); #1;
        end
        mem_rvalid = 1'b0;
        chk1("abort_idle_req", mem_req, 1'b0);
        chk1("abort_idle_stall", pc_stall, 1'b0);
        return;
      end
      mem_rvalid = 1'b1;
      mem_rdata = word_val(line + 32'(b * 4));
      flush = (b == flush_beat);
      @(posedge CLK); #1;
      mem_rvalid = 1'b0;
      flush = 1'b0;
    end
    model_touch(a);
    if (flush_beat >= 0) model_clear();
  endtask

  // One fetch presented in IDLE, checked against the model; a miss is refilled.
  task automatic access(input logic [31:0] a, input logic fl, input int flush_beat, input int abort_beat);
    logic exp_hit;
    pc = a;
    pc_valid = 1'b1;
    flush = fl;
    exp_hit = model_hit(a);
    @(negedge CLK);
    chk1("acc_rd_valid", rd_valid, exp_hit);
    chk1("acc_stall", pc_stall, !exp_hit);
    chk("acc_rd", rd, exp_hit ? word_val(a) : NOP);
    last_hit = rd_valid;
    last_rd = rd;
    @(posedge CLK); #1;
    flush = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    if (exp_hit) exp_hits++;
    else exp_miss++;
`endif
    if (exp_hit) model_touch(a);
    if (fl) model_clear();
    if (!exp_hit) refill(a, flush_beat, abort_beat);
    pc_valid = 1'b0;
  endtask

  task automatic acc(input logic [31:0] a);
    access(a, 1'b0, -1, -1);
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    model_clear();
    #3;
    do_reset();

    // Cold miss on 0x100, refill 0xA0..0xA7, then hits.
    acc(32'h100);
    chk1("c037_cold_miss", last_hit, 1'b0);
    acc(32'h100);
    chk("c037_rd0", last_rd, 32'hA0);
    acc(32'h104);
    chk("c037_rd1", last_rd, 32'hA1);
    chk1("c037_hit1", last_hit, 1'b1);

    // Grant/beat outside their states must do nothing.
    idle_step(1'b0);
    idle_step(1'b0);

    // LRU eviction within set 0.
    idle_step(1'b1);
    acc(32'h000);
    acc(32'h200);
    acc(32'h000);
    chk1("c038_hit000", last_hit, 1'b1);
    acc(32'h400);
    chk1("c038_miss400", last_hit, 1'b0);
    acc(32'h000);
    chk1("c038_keep000", last_hit, 1'b1);
    acc(32'h200);
    chk1("c038_evict200", last_hit, 1'b0);

    // Flush in IDLE concurrent with a hit still returns data.
    acc(32'h100);
    access(32'h108, 1'b1, -1, -1);
    chk("c029_flush_hit_rd", last_rd, 32'hA2);
    acc(32'h100);
    chk1("c029_after_flush", last_hit, 1'b0);

    // Flush during refill: line completes but is invalid afterwards.
    idle_step(1'b1);
    access(32'h100, 1'b0, 3, -1);
    acc(32'h100);
    chk1("c039_miss_again", last_hit, 1'b0);
    acc(32'h100);
    chk1("c039_hit_after", last_hit, 1'b1);

    // Reset in the middle of a refill.
    idle_step(1'b1);
    access(32'h100, 1'b0, -1, 4);
    acc(32'h100);
    chk1("c040_miss_after_rst", last_hit, 1'b0);
    acc(32'h11C);
    chk("c040_rd7", last_rd, 32'hA7);

    // Random traffic over two sets and four tags, with occasional flushes.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_step($urandom_range(0, 3) == 0);
      end else begin
        a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 1) << 5) |
            ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        access(a, ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1, -1);
        if (!last_hit && $urandom_range(0, 1) == 1) acc(a);
      end
    end

`ifdef ICACHE_PERF_CNT_EN
    chk("perf_hits_model", hit_cnt, 32'(exp_hits));
    chk("perf_miss_model", miss_cnt, 32'(exp_miss));
    do_reset();
    chk("perf_rst_hit", hit_cnt, 32'd0);
    acc(32'h100);
    for (int i = 1; i < 8; i++) acc(32'h100 + 32'(i * 4));
    chk("perf_miss_cnt", miss_cnt, 32'd1);
    chk("perf_hit_cnt", hit_cnt, 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
